fetch_align: RTL

//  Instruction aligner between I-fetch and the instruction queue. Takes FW-bit fetch packets,

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/fetch_parcel_scan.sv | 101 ++++++++++
 rtl/fetch_align.sv | 138 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and helpers for the fetch aligner, queue and decode
package fetch_pkg;

    localparam int FA_XLEN = 32;

    typedef logic [15:0] parcel_t;

    typedef struct packed {
        logic [31:0]        instr;
        logic [FA_XLEN-1:0] pc;
        logic               rvc;
    } fa_elem_t;

    function automatic logic is_rvc(input parcel_t p);
        return p[1:0] != 2'b11;
    endfunction

    function automatic int nparcel_of(input int fw);
        return fw / 16;
    endfunction

    function automatic int ocw_of(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fetch_parcel_scan.sv
// rtl/fetch_parcel_scan.sv - combinational parcel walk producing up to OUT_NENTRY instructions
module fetch_parcel_scan
    import fetch_pkg::*;
#(
    parameter int XLEN       = FA_XLEN,
    parameter int NPARCEL    = 4,
    parameter int OUT_NENTRY = 2,
    parameter int OCW        = ocw_of(OUT_NENTRY),
    parameter int PW         = $clog2(NPARCEL + 1),
    parameter int PIW        = $clog2(NPARCEL)
) (
    input  parcel_t [NPARCEL-1:0] parcels,
    input  logic [PW-1:0]         ptr,
    input  logic                  half_vld,
    input  parcel_t               half_lo,
    input  logic [XLEN-1:0]       half_pc,
    input  logic [XLEN-1:0]       pkt_pc,
    output fa_elem_t              elems [OUT_NENTRY],
    output logic [OCW-1:0]        cnt,
    output logic [PW-1:0]         parcels_used,
    output logic                  has_trailing_half,
    output logic                  last_emit
);

    localparam logic [PW-1:0]  NP   = PW'(NPARCEL);
    localparam logic [PW-1:0]  LAST = PW'(NPARCEL - 1);
    localparam logic [OCW-1:0] MAXN = OCW'(OUT_NENTRY);

    logic [PW-1:0]  p;
    logic [PW-1:0]  used;
    logic [1:0]     len;
    logic [OCW-1:0] n;
    logic           hv;
    logic           emit;
    logic           more;
    logic           trailing;
    parcel_t        cur;
    parcel_t        nxt;
    fa_elem_t       e;

    // Walk the whole remainder of the packet so that "more work left" and the
    // trailing-half condition are known even when the output slots are full.
    always_comb begin
        for (int s = 0; s < OUT_NENTRY; s++) elems[s] = '0;
        p        = ptr;
        hv       = half_vld;
        used     = '0;
        n        = '0;
        more     = 1'b0;
        trailing = 1'b0;
        len      = 2'd0;
        emit     = 1'b0;
        cur      = '0;
        nxt      = '0;
        e        = '0;
        for (int k = 0; k < NPARCEL; k++) begin
            len  = 2'd0;
            emit = 1'b0;
            e    = '0;
            if (p < NP) begin
                cur  = parcels[p[PIW-1:0]];
                nxt  = parcels[p[PIW-1:0] + PIW'(1)];
                e.pc = pkt_pc + XLEN'({p, 1'b0});
                len  = 2'd1;
                emit = 1'b1;
                if (hv) begin
                    e.instr = {cur, half_lo};
                    e.pc    = half_pc;
                    hv      = 1'b0;
                end else if (is_rvc(cur)) begin
                    e.instr = {16'h0000, cur};
                    e.rvc   = 1'b1;
                end else if (p == LAST) begin
                    emit     = 1'b0;
                    trailing = 1'b1;
                end else begin
                    e.instr = {nxt, cur};
                    len     = 2'd2;
                end
                if (emit) begin
                    if (n < MAXN) begin
                        for (int s = 0; s < OUT_NENTRY; s++) begin
                            if (n == OCW'(s)) elems[s] = e;
                        end
                        used = used + PW'(len);
                        n    = n + OCW'(1);
                    end else begin
                        more = 1'b1;
                    end
                end
                p = p + PW'(len);
            end
        end
    end

    assign cnt               = n;
    assign parcels_used      = used;
    assign has_trailing_half = trailing;
    assign last_emit         = (n != '0) && !more;

endmodule

// File: rtl/fetch_align.sv
// rtl/fetch_align.sv - aligns fetch packets into whole RVC/32-bit instructions for the queue
module fetch_align
    import fetch_pkg::*;
#(
    parameter int  XLEN       = FA_XLEN,
    parameter int  FW         = 64,
    parameter int  OUT_NENTRY = 2,
    localparam int NPARCEL    = nparcel_of(FW),
    localparam int OCW        = ocw_of(OUT_NENTRY),
    localparam int PW         = $clog2(NPARCEL + 1),
    localparam int PIW        = $clog2(NPARCEL)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            fv,
    output logic            frdy,
    input  logic [FW-1:0]   fdata,
    input  logic [XLEN-1:0] fpc,
    input  logic [PIW-1:0]  foff,
    output logic            dout_val,
    output logic [OCW-1:0]  dout_val_cnt,
    input  logic            dout_rdy,
    output fa_elem_t        dout [OUT_NENTRY]
);

    localparam logic [XLEN-1:0] HALF_OFS = XLEN'(2 * (NPARCEL - 1));

    logic                pkt_vld_q, pkt_vld_d;
    logic [FW-1:0]       pkt_data_q, pkt_data_d;
    logic [XLEN-1:0]     pkt_pc_q, pkt_pc_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic                half_vld_q, half_vld_d;
    parcel_t             half_lo_q, half_lo_d;
    logic [XLEN-1:0]     half_pc_q, half_pc_d;

    parcel_t [NPARCEL-1:0] parcels;
    fa_elem_t            scan_elems [OUT_NENTRY];
    logic [OCW-1:0]      scan_cnt;
    logic [PW-1:0]       scan_used;
    logic                scan_trailing;
    logic                scan_last;
    logic                consume;
    logic                retire;
    logic                accept;

    assign parcels = pkt_data_q;

    fetch_parcel_scan #(
        .XLEN       (XLEN),
        .NPARCEL    (NPARCEL),
        .OUT_NENTRY (OUT_NENTRY),
        .OCW        (OCW),
        .PW         (PW),
        .PIW        (PIW)
    ) u_scan (
        .parcels           (parcels),
        .ptr               (ptr_q),
        .half_vld          (half_vld_q),
        .half_lo           (half_lo_q),
        .half_pc           (half_pc_q),
        .pkt_pc            (pkt_pc_q),
        .elems             (scan_elems),
        .cnt               (scan_cnt),
        .parcels_used      (scan_used),
        .has_trailing_half (scan_trailing),
        .last_emit         (scan_last)
    );

    // A packet with nothing emittable left (only a trailing half) retires at once.
    assign dout_val = rst_n && pkt_vld_q && (scan_cnt != '0) && !flush;
    assign consume  = dout_val && dout_rdy;
    assign retire   = rst_n && pkt_vld_q && !flush && ((scan_cnt == '0) || (consume && scan_last));
    assign frdy     = rst_n && !flush && (!pkt_vld_q || retire);
    assign accept   = fv && frdy;

    assign dout_val_cnt = dout_val ? scan_cnt : '0;

    always_comb begin
        for (int s = 0; s < OUT_NENTRY; s++) begin
            dout[s] = dout_val ? scan_elems[s] : '0;
        end
    end

    always_comb begin
        pkt_vld_d  = pkt_vld_q;
        pkt_data_d = pkt_data_q;
        pkt_pc_d   = pkt_pc_q;
        ptr_d      = ptr_q;
        half_vld_d = half_vld_q;
        half_lo_d  = half_lo_q;
        half_pc_d  = half_pc_q;
        if (consume) begin
            ptr_d      = ptr_q + scan_used;
            half_vld_d = 1'b0;
        end
        if (retire) begin
            pkt_vld_d = 1'b0;
            if (scan_trailing) begin
                half_vld_d = 1'b1;
                half_lo_d  = parcels[NPARCEL-1];
                half_pc_d  = pkt_pc_q + HALF_OFS;
            end
        end
        if (accept) begin
            pkt_vld_d  = 1'b1;
            pkt_data_d = fdata;
            pkt_pc_d   = fpc;
            ptr_d      = PW'(foff);
        end
        if (flush) begin
            pkt_vld_d  = 1'b0;
            half_vld_d = 1'b0;
            ptr_d      = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pkt_vld_q  <= 1'b0;
            half_vld_q <= 1'b0;
            ptr_q      <= '0;
        end else begin
            pkt_vld_q  <= pkt_vld_d;
            pkt_data_q <= pkt_data_d;
            pkt_pc_q   <= pkt_pc_d;
            ptr_q      <= ptr_d;
            half_vld_q <= half_vld_d;
            half_lo_q  <= half_lo_d;
            half_pc_q  <= half_pc_d;
        end
    end

    // A held half-instruction must be completed by the sequentially next packet.
    assert property (@(posedge clk) disable iff (!rst_n)
        (fv && half_vld_q && !flush) |-> (foff == '0 && fpc == half_pc_q + XLEN'(2)));

endmodule
